// File: rtl/ws2812_bit_encoder.sv
// WS2812 single-wire NRZ serialiser: takes 24-bit GRB pixels over valid/ready,
// drives led_out MSB first, and holds the line low for a latch period after the last pixel.
module ws2812_bit_encoder #(
  parameter int T0H     = 16,
  parameter int T1H     = 32,
  parameter int T_BIT   = 50,
  parameter int T_RESET = 2000,
  parameter int CNT_W   = 11
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  input  logic        pixel_last,
  output logic        pixel_ready,
  output logic        led_out,
  output logic        busy,
  output logic        underrun
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_HIGH = 2'd1,
    SHIFT_LOW  = 2'd2,
    LATCH      = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       bit_idx_r;
  logic [23:0]      shift_r;
  logic             last_r;
  logic             led_r;
  logic             busy_r;
  logic             underrun_r;

  logic [CNT_W-1:0] high_time_s;
  logic             bit_end_s;
  logic             pixel_end_s;
  logic             xfer_s;

  // Bit timing decode and handshake; cnt_r is the index of the current cycle within the bit.
  always_comb begin
    high_time_s = shift_r[23] ? CNT_W'(T1H) : CNT_W'(T0H);
    bit_end_s   = (state_r == SHIFT_LOW) && (cnt_r == CNT_W'(T_BIT - 1));
    pixel_end_s = bit_end_s && (bit_idx_r == 5'd0);
    pixel_ready = (state_r == IDLE) || (pixel_end_s && !last_r);
    xfer_s      = pixel_valid && pixel_ready;
  end

  // Main sequencer; led_out is registered alongside the state so it is high exactly in SHIFT_HIGH.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      bit_idx_r  <= 5'd23;
      shift_r    <= 24'd0;
      last_r     <= 1'b0;
      led_r      <= 1'b0;
      busy_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      if (xfer_s) begin
        // Accept from IDLE, or gaplessly at the end of a non-last pixel.
        state_r   <= SHIFT_HIGH;
        cnt_r     <= {CNT_W{1'b0}};
        bit_idx_r <= 5'd23;
        shift_r   <= pixel_data;
        last_r    <= pixel_last;
        led_r     <= 1'b1;
        busy_r    <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            led_r  <= 1'b0;
            busy_r <= 1'b0;
          end
          SHIFT_HIGH: begin
            cnt_r <= cnt_r + CNT_W'(1);
            if ((cnt_r + CNT_W'(1)) == high_time_s) begin
              state_r <= SHIFT_LOW;
              led_r   <= 1'b0;
            end
          end
          SHIFT_LOW: begin
            if (!bit_end_s) begin
              cnt_r <= cnt_r + CNT_W'(1);
            end else if (bit_idx_r != 5'd0) begin
              state_r   <= SHIFT_HIGH;
              cnt_r     <= {CNT_W{1'b0}};
              bit_idx_r <= bit_idx_r - 5'd1;
              shift_r   <= {shift_r[22:0], 1'b0};
              led_r     <= 1'b1;
            end else if (last_r) begin
              state_r <= LATCH;
              cnt_r   <= {CNT_W{1'b0}};
            end else begin
              state_r    <= IDLE;
              cnt_r      <= {CNT_W{1'b0}};
              busy_r     <= 1'b0;
              underrun_r <= 1'b1;
            end
          end
          LATCH: begin
            if (cnt_r == CNT_W'(T_RESET - 1)) begin
              state_r <= IDLE;
              cnt_r   <= {CNT_W{1'b0}};
              busy_r  <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            led_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign led_out  = led_r;
  assign busy     = busy_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Self-checking bench for ws2812_bit_encoder with shortened timing; expected line
// levels come from a per-cycle waveform queue built directly from the pixel bits.
module tb_ws2812_bit_encoder;
  localparam int T0H     = 2;
  localparam int T1H     = 4;
  localparam int T_BIT   = 6;
  localparam int T_RESET = 10;
  localparam int PIX     = 24 * T_BIT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] data = 24'd0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic        ready, led, busy, underrun;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  ws2812_bit_encoder #(.T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RESET(T_RESET), .CNT_W(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .pixel_data(data), .pixel_valid(valid),
    .pixel_last(last), .pixel_ready(ready), .led_out(led), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waveform of one pixel: per bit, high for T1H or T0H cycles then low to T_BIT.
  task automatic push_pixel(input logic [23:0] w);
    for (int b = 23; b >= 0; b--)
      for (int p = 0; p < T_BIT; p++)
        exp_q.push_back(p < (w[b] ? T1H : T0H));
  endtask

  task automatic push_latch();
    for (int i = 0; i < T_RESET; i++) exp_q.push_back(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b0;
      tick();
      total += 4;
      if (led !== 1'b0)      begin bad++; $display("FAIL reset_led i=%0d got=%b exp=0", i, led); end
      if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy i=%0d got=%b exp=0", i, busy); end
      if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun i=%0d got=%b exp=0", i, underrun); end
      if (ready !== 1'b1)    begin bad++; $display("FAIL reset_ready i=%0d got=%b exp=1", i, ready); end
    end
  endtask

  task automatic test_single();
    bit e;
    exp_q.delete();
    data = 24'hA50000; last = 1'b1; valid = 1'b1;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%b exp=1", ready); end
    push_pixel(24'hA50000);
    push_latch();
    for (int k = 1; k <= PIX + T_RESET; k++) begin
      tick();
      if (k == 1) valid = 1'b0;
      e = exp_q.pop_front();
      total += 4;
      if (led !== e)         begin bad++; $display("FAIL single_led cyc=%0d got=%b exp=%b", k, led, e); end
      if (busy !== 1'b1)     begin bad++; $display("FAIL single_busy cyc=%0d got=%b exp=1", k, busy); end
      if (ready !== 1'b0)    begin bad++; $display("FAIL single_ready cyc=%0d got=%b exp=0", k, ready); end
      if (underrun !== 1'b0) begin bad++; $display("FAIL single_underrun cyc=%0d got=%b exp=0", k, underrun); end
    end
    tick();
    total += 3;
    if (ready !== 1'b1) begin bad++; $display("FAIL single_end_ready got=%b exp=1", ready); end
    if (busy !== 1'b0)  begin bad++; $display("FAIL single_end_busy got=%b exp=0", busy); end
    if (led !== 1'b0)   begin bad++; $display("FAIL single_end_led got=%b exp=0", led); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] w1, w2;
    bit e;
    for (int it = 0; it < 3; it++) begin
      w1 = (it == 0) ? 24'hFFFFFF : 24'($urandom);
      w2 = (it == 0) ? 24'h000000 : 24'($urandom);
      exp_q.delete();
      push_pixel(w1);
      push_pixel(w2);
      push_latch();
      data = w1; last = 1'b0; valid = 1'b1;
      for (int k = 1; k <= 2 * PIX + T_RESET; k++) begin
        tick();
        // New data presented early must not disturb the pixel being sent.
        if (k == 1) begin data = w2; last = 1'b1; end
        if (k == PIX + 1) valid = 1'b0;
        e = exp_q.pop_front();
        total += 4;
        if (led !== e) begin bad++; $display("FAIL b2b_led it=%0d cyc=%0d got=%b exp=%b", it, k, led, e); end
        if (ready !== (k == PIX)) begin bad++; $display("FAIL b2b_ready it=%0d cyc=%0d got=%b exp=%b", it, k, ready, (k == PIX)); end
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy it=%0d cyc=%0d got=%b exp=1", it, k, busy); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun it=%0d cyc=%0d got=%b exp=0", it, k, underrun); end
      end
      tick();
      total += 2;
      if (ready !== 1'b1) begin bad++; $display("FAIL b2b_end_ready it=%0d got=%b exp=1", it, ready); end
      if (busy !== 1'b0)  begin bad++; $display("FAIL b2b_end_busy it=%0d got=%b exp=0", it, busy); end
    end
  endtask

  task automatic test_underrun();
    logic [23:0] w;
    bit e;
    w = 24'($urandom) | 24'd1;
    exp_q.delete();
    push_pixel(w);
    data = w; last = 1'b0; valid = 1'b1;
    for (int k = 1; k <= PIX; k++) begin
      tick();
      if (k == 1) valid = 1'b0;
      e = exp_q.pop_front();
      total += 2;
      if (led !== e) begin bad++; $display("FAIL ur_led cyc=%0d got=%b exp=%b", k, led, e); end
      if (underrun !== 1'b0) begin bad++; $display("FAIL ur_early cyc=%0d got=%b exp=0", k, underrun); end
    end
    tick();
    total += 4;
    if (underrun !== 1'b1) begin bad++; $display("FAIL ur_pulse got=%b exp=1", underrun); end
    if (ready !== 1'b1)    begin bad++; $display("FAIL ur_ready got=%b exp=1", ready); end
    if (led !== 1'b0)      begin bad++; $display("FAIL ur_led_idle got=%b exp=0", led); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL ur_busy got=%b exp=0", busy); end
    tick();
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL ur_pulse_len got=%b exp=0", underrun); end
  endtask

  task automatic test_latch_valid();
    logic [23:0] w1, w2;
    bit e;
    w1 = 24'($urandom);
    w2 = 24'($urandom) | 24'h800000;
    exp_q.delete();
    push_pixel(w1);
    push_latch();
    data = w1; last = 1'b1; valid = 1'b1;
    for (int k = 1; k <= PIX + T_RESET + 1; k++) begin
      tick();
      if (k == 1) valid = 1'b0;
      if (k == PIX + 2) begin valid = 1'b1; data = w2; last = 1'b1; end
      e = (k <= PIX + T_RESET) ? exp_q.pop_front() : 1'b0;
      total += 2;
      if (led !== e) begin bad++; $display("FAIL lv_led cyc=%0d got=%b exp=%b", k, led, e); end
      if (ready !== (k == PIX + T_RESET + 1)) begin bad++; $display("FAIL lv_ready cyc=%0d got=%b exp=%b", k, ready, (k == PIX + T_RESET + 1)); end
    end
    push_pixel(w2);
    push_latch();
    for (int k = PIX + T_RESET + 2; k <= 2 * (PIX + T_RESET) + 1; k++) begin
      tick();
      if (k == PIX + T_RESET + 2) valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin bad++; $display("FAIL lv_led2 cyc=%0d got=%b exp=%b", k, led, e); end
    end
    tick();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL lv_end_ready got=%b exp=1", ready); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] w;
    bit e;
    int n, guard;
    data = 24'($urandom); last = 1'b1; valid = 1'b1;
    n = $urandom_range(1, 100);
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == 1) valid = 1'b0;
    end
    guard = 0;
    while (led !== 1'b1 && guard < 2 * T_BIT) begin
      tick();
      guard++;
    end
    total++;
    if (led !== 1'b1) begin bad++; $display("FAIL rm_no_high got=%b exp=1", led); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 4;
    if (led !== 1'b0)      begin bad++; $display("FAIL rm_led got=%b exp=0", led); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    if (underrun !== 1'b0) begin bad++; $display("FAIL rm_underrun got=%b exp=0", underrun); end
    if (ready !== 1'b1)    begin bad++; $display("FAIL rm_ready got=%b exp=1", ready); end
    for (int k = 0; k < 2 * T_RESET; k++) begin
      tick();
      total += 3;
      if (busy !== 1'b0)     begin bad++; $display("FAIL rm_idle_busy k=%0d got=%b exp=0", k, busy); end
      if (underrun !== 1'b0) begin bad++; $display("FAIL rm_idle_underrun k=%0d got=%b exp=0", k, underrun); end
      if (led !== 1'b0)      begin bad++; $display("FAIL rm_idle_led k=%0d got=%b exp=0", k, led); end
    end
    w = 24'($urandom);
    exp_q.delete();
    push_pixel(w);
    push_latch();
    data = w; last = 1'b1; valid = 1'b1;
    for (int k = 1; k <= PIX + T_RESET; k++) begin
      tick();
      if (k == 1) valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (led !== e) begin bad++; $display("FAIL rm_fresh_led cyc=%0d got=%b exp=%b", k, led, e); end
    end
    tick();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL rm_end_ready got=%b exp=1", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_latch_valid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
